// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate data cache
// sitting between the CPU load/store port and the main memory word port.
module cache_controller #(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_done,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

  state_t r_state;
  state_t w_nextState;

  // Line storage; data and tags are deliberately not reset, valid/dirty are.
  logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  // Latched request; the byte-offset bits are never needed.
  logic                 r_we;
  logic [ADDR_W-3:0]    r_wordAddr;
  logic [31:0]          r_wdata;
  logic [OFF_W-1:0]     r_beat;
  logic                 r_refilled;

  logic [TAG_W-1:0]     w_reqTag;
  logic [IDX_W-1:0]     w_idx;
  logic [OFF_W-1:0]     w_word;
  logic                 w_hit;
  logic                 w_beatDone;
  logic                 w_lastBeat;
  logic                 w_unusedByteBits;

  assign w_reqTag         = r_wordAddr[ADDR_W-3 -: TAG_W];
  assign w_idx            = r_wordAddr[OFF_W +: IDX_W];
  assign w_word           = r_wordAddr[OFF_W-1:0];
  assign w_hit            = r_valid[w_idx] && (r_tag[w_idx] == w_reqTag);
  assign w_beatDone       = mem_req && mem_done;
  assign w_lastBeat       = (r_beat == LAST_BEAT);
  assign w_unusedByteBits = ^cpu_addr[1:0];
  assign cpu_busy         = (r_state != IDLE);

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state decode and memory-port drive; the port is idle outside the burst states.
  always_comb begin
    w_nextState = r_state;
    mem_req     = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (cpu_req) w_nextState = COMPARE;
      end
      COMPARE: begin
        if (w_hit)                                 w_nextState = IDLE;
        else if (r_valid[w_idx] && r_dirty[w_idx]) w_nextState = WRITEBACK;
        else                                       w_nextState = REFILL;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, r_beat, 2'b00};
        mem_wdata = r_data[w_idx][r_beat];
        if (w_beatDone && w_lastBeat) w_nextState = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_reqTag, w_idx, r_beat, 2'b00};
        if (w_beatDone && w_lastBeat) w_nextState = COMPARE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request latch, beat counter, line status bits, CPU response and hit/miss counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_we       <= 1'b0;
      r_wordAddr <= '0;
      r_wdata    <= '0;
      r_beat     <= '0;
      r_refilled <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_beat     <= '0;
          r_refilled <= 1'b0;
          if (cpu_req) begin
            r_we       <= cpu_we;
            r_wordAddr <= cpu_addr[ADDR_W-1:2];
            r_wdata    <= cpu_wdata;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            cpu_ready <= 1'b1;
            if (r_we) r_dirty[w_idx] <= 1'b1;
            else      cpu_rdata      <= r_data[w_idx][w_word];
            if (!r_refilled && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else if (miss_count != 16'hFFFF) begin
            miss_count <= miss_count + 16'd1;
          end
        end
        WRITEBACK: begin
          if (w_beatDone) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_lastBeat) r_dirty[w_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (w_beatDone) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_lastBeat) begin
              r_valid[w_idx] <= 1'b1;
              r_refilled     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays: refill beats fill words, store hits merge the CPU word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == REFILL && w_beatDone) begin
        r_data[w_idx][r_beat] <= mem_rdata;
        if (w_lastBeat) r_tag[w_idx] <= w_reqTag;
      end else if (r_state == COMPARE && w_hit && r_we) begin
        r_data[w_idx][w_word] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed table, hand-built corner sequences and
// random accesses checked against an architectural cache/memory model.
module tb_cache_controller;

  logic        clk, reset, cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_busy, mem_req, mem_rw;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_done;
  logic [15:0] hit_count, miss_count;

  cache_controller dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .mem_req(mem_req),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expHit;
    int          expWr;
    int          expRd;
    int          expHits;
    int          expMisses;
  } vec_t;

  int testsRun = 0;
  int testsFailed = 0;

  // Memory device state
  logic [31:0] memModel [256];
  beat_t       beatLog [$];
  int          maxStall = 0;
  int          stallLeft = 0;
  bit          stallArmed = 0;
  logic [9:0]  stallAddr = 10'h0;
  int          consecErr = 0;
  int          stabErr = 0;

  // Architectural reference model
  logic [31:0] refMem [256];
  logic [3:0]  refTag [4];
  bit          refValid [4];
  bit          refDirty [4];
  int          modelHits, modelMisses;
  beat_t       expBeats [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Memory responder: decides done/read data at each falling edge.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (stallArmed && mem_addr == stallAddr) begin
          stallArmed = 0;
          stallLeft  = 5;
        end
        if (stallLeft == 0) begin
          mem_done  = 1'b1;
          mem_rdata = memModel[mem_addr[9:2]];
          stallLeft = int'($urandom_range(maxStall, 0));
        end else begin
          mem_done  = 1'b0;
          stallLeft--;
        end
      end else begin
        mem_done = 1'b0;
      end
    end
  end

  // Memory storage, beat log and protocol monitors at each rising edge.
  initial begin
    logic        prevStall, prevReady, pReq, pRw;
    logic [9:0]  pAddr;
    logic [31:0] pWdata;
    beat_t       b;
    for (int i = 0; i < 256; i++) memModel[i] = 32'h1000_0000 + 32'(i);
    memModel[4] = 32'h1122_3344;
    prevStall = 1'b0;
    prevReady = 1'b0;
    pReq = 1'b0; pRw = 1'b0; pAddr = '0; pWdata = '0;
    forever begin
      @(posedge clk);
      if (mem_req === 1'b1 && mem_done === 1'b1) begin
        b.rw   = mem_rw;
        b.addr = mem_addr;
        b.data = mem_rw ? mem_wdata : mem_rdata;
        beatLog.push_back(b);
        if (mem_rw) memModel[mem_addr[9:2]] = mem_wdata;
      end
      if (prevStall && (mem_req !== pReq || mem_rw !== pRw || mem_addr !== pAddr || mem_wdata !== pWdata))
        stabErr++;
      if (cpu_ready === 1'b1 && prevReady) consecErr++;
      prevReady = (cpu_ready === 1'b1);
      prevStall = (mem_req === 1'b1) && (mem_done !== 1'b1) && (reset !== 1'b1);
      pReq = mem_req; pRw = mem_rw; pAddr = mem_addr; pWdata = mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] satCount(input int c);
    return (c > 65535) ? 16'hFFFF : 16'(c);
  endfunction

  task automatic modelSync();
    for (int i = 0; i < 256; i++) refMem[i] = memModel[i];
    for (int i = 0; i < 4; i++) begin
      refValid[i] = 0;
      refDirty[i] = 0;
      refTag[i]   = '0;
    end
    modelHits   = 0;
    modelMisses = 0;
  endtask

  task automatic modelAccess(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                             output logic [31:0] expRdata, output bit expHit);
    logic [1:0] li;
    logic [3:0] tag;
    logic [7:0] w;
    logic [9:0] a;
    beat_t      b;
    li  = addr[5:4];
    tag = addr[9:6];
    w   = addr[9:2];
    expBeats.delete();
    expHit = refValid[li] && (refTag[li] == tag);
    if (expHit) begin
      modelHits++;
    end else begin
      modelMisses++;
      if (refValid[li] && refDirty[li]) begin
        for (int k = 0; k < 4; k++) begin
          a = {refTag[li], li, 2'(k), 2'b00};
          b.rw = 1'b1; b.addr = a; b.data = refMem[a[9:2]];
          expBeats.push_back(b);
        end
      end
      for (int k = 0; k < 4; k++) begin
        b.rw = 1'b0; b.addr = {tag, li, 2'(k), 2'b00}; b.data = '0;
        expBeats.push_back(b);
      end
      refValid[li] = 1;
      refDirty[li] = 0;
      refTag[li]   = tag;
    end
    if (we) begin
      refMem[w]    = wdata;
      refDirty[li] = 1;
    end
    expRdata = refMem[w];
  endtask

  task automatic checkTraffic(input string name, input int start);
    int n, bad;
    n = beatLog.size() - start;
    checkOutput({name, " beat count"}, n, expBeats.size());
    if (n == expBeats.size()) begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (beatLog[start+i].rw !== expBeats[i].rw || beatLog[start+i].addr !== expBeats[i].addr ||
            (expBeats[i].rw && beatLog[start+i].data !== expBeats[i].data))
          bad++;
      end
      checkOutput({name, " beat content errors"}, bad, 0);
    end
  endtask

  task automatic startRequest(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
  endtask

  task automatic waitReady(input string name, output logic [31:0] rdata, output int cycles);
    bit ok;
    ok = 0;
    cycles = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (cpu_ready === 1'b1) ok = 1;
      else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    checkOutput({name, " ready seen"}, ok, 1);
    rdata = cpu_rdata;
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [9:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata, output int cycles);
    startRequest(we, addr, wdata);
    waitReady(name, rdata, cycles);
  endtask

  task automatic waitBeat(input string name, input logic rw, input logic [9:0] addr);
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1 && mem_rw === rw && mem_addr === addr) found = 1;
    end
    checkOutput({name, " beat reached"}, found, 1);
  endtask

  task automatic countBeats(input int start, output int nWr, output int nRd);
    nWr = 0;
    nRd = 0;
    for (int i = start; i < beatLog.size(); i++) begin
      if (beatLog[i].rw) nWr++;
      else               nRd++;
    end
  endtask

  initial begin
    vec_t        vecs [5];
    logic [31:0] rdata, expRdata;
    bit          expHit;
    int          cycles, start, nWr, nRd, readySeen;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;

    vecs[0] = '{1'b0, 10'h010, 32'h0,        32'h1122_3344, 1'b0, 0, 4, 0, 1};
    vecs[1] = '{1'b0, 10'h014, 32'h0,        32'h1000_0005, 1'b1, 0, 0, 1, 1};
    vecs[2] = '{1'b1, 10'h018, 32'hDEADBEEF, 32'hDEADBEEF,  1'b1, 0, 0, 2, 1};
    vecs[3] = '{1'b0, 10'h018, 32'h0,        32'hDEADBEEF,  1'b1, 0, 0, 3, 1};
    vecs[4] = '{1'b0, 10'h058, 32'h0,        32'h1000_0016, 1'b0, 4, 4, 3, 2};

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelSync();

    checkOutput("reset cpu_ready", cpu_ready, 0);
    checkOutput("reset cpu_rdata", cpu_rdata, 0);
    checkOutput("reset cpu_busy", cpu_busy, 0);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_rw", mem_rw, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset mem_wdata", mem_wdata, 0);
    checkOutput("reset hit_count", hit_count, 0);
    checkOutput("reset miss_count", miss_count, 0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      modelAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, expRdata, expHit);
      start = beatLog.size();
      applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, cycles);
      if (!vecs[i].we) checkOutput($sformatf("vec%0d load data", i), rdata, vecs[i].expRdata);
      if (vecs[i].expHit) checkOutput($sformatf("vec%0d hit latency", i), cycles, 2);
      countBeats(start, nWr, nRd);
      checkOutput($sformatf("vec%0d write beats", i), nWr, vecs[i].expWr);
      checkOutput($sformatf("vec%0d read beats", i), nRd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d hit_count", i), hit_count, vecs[i].expHits);
      checkOutput($sformatf("vec%0d miss_count", i), miss_count, vecs[i].expMisses);
      checkTraffic($sformatf("vec%0d", i), start);
    end

    // Stall of five cycles on refill beat 1 (address 0x054)
    modelAccess(1'b0, 10'h014, 32'h0, expRdata, expHit);
    start = beatLog.size();
    applyStimulus("reload014", 1'b0, 10'h014, 32'h0, rdata, cycles);
    checkOutput("reload014 data", rdata, 32'h1000_0005);
    checkTraffic("reload014", start);

    modelAccess(1'b0, 10'h058, 32'h0, expRdata, expHit);
    start = beatLog.size();
    stallAddr  = 10'h054;
    stallArmed = 1;
    startRequest(1'b0, 10'h058, 32'h0);
    waitBeat("stall", 1'b0, 10'h054);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall hold addr c%0d", k), mem_addr, 10'h054);
      checkOutput($sformatf("stall hold req c%0d", k), mem_req, 1);
    end
    waitReady("stall", rdata, cycles);
    checkOutput("stall load data", rdata, 32'h1000_0016);
    checkTraffic("stall", start);

    // Reset during writeback beat 1
    modelAccess(1'b1, 10'h054, 32'hCAFEF00D, expRdata, expHit);
    start = beatLog.size();
    applyStimulus("dirty054", 1'b1, 10'h054, 32'hCAFEF00D, rdata, cycles);
    checkOutput("dirty054 hit latency", cycles, 2);
    checkTraffic("dirty054", start);

    stallAddr  = 10'h054;
    stallArmed = 1;
    startRequest(1'b0, 10'h014, 32'h0);
    waitBeat("abort", 1'b1, 10'h054);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort mem_req", mem_req, 0);
    checkOutput("abort cpu_busy", cpu_busy, 0);
    checkOutput("abort cpu_ready", cpu_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    readySeen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (cpu_ready === 1'b1) readySeen++;
    end
    checkOutput("abort no ready", readySeen, 0);
    modelSync();

    modelAccess(1'b0, 10'h014, 32'h0, expRdata, expHit);
    start = beatLog.size();
    applyStimulus("post-reset", 1'b0, 10'h014, 32'h0, rdata, cycles);
    checkOutput("post-reset load data", rdata, 32'h1000_0005);
    checkOutput("post-reset miss_count", miss_count, 1);
    countBeats(start, nWr, nRd);
    checkOutput("post-reset write beats", nWr, 0);
    checkTraffic("post-reset", start);

    // Random accesses against the reference model
    maxStall = 2;
    for (int n = 0; n < 300; n++) begin
      we    = 1'($urandom_range(1, 0));
      addr  = {4'($urandom_range(2, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
               2'($urandom_range(3, 0))};
      wdata = $urandom;
      modelAccess(we, addr, wdata, expRdata, expHit);
      start = beatLog.size();
      applyStimulus($sformatf("rand%0d", n), we, addr, wdata, rdata, cycles);
      if (!we) checkOutput($sformatf("rand%0d load data @%h", n, addr), rdata, expRdata);
      if (expHit) checkOutput($sformatf("rand%0d hit latency", n), cycles, 2);
      checkOutput($sformatf("rand%0d hit_count", n), hit_count, satCount(modelHits));
      checkOutput($sformatf("rand%0d miss_count", n), miss_count, satCount(modelMisses));
      checkTraffic($sformatf("rand%0d", n), start);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("ready back-to-back count", consecErr, 0);
    checkOutput("stalled port change count", stabErr, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
